// File: rtl/addsub_pipe_stage_if.sv
// Request/result handshake bundle for the add/sub pipeline stage.
// master = ALU issue/writeback side, slave = the pipeline itself.
interface addsub_pipe_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_overflow;
  logic             out_zero;
  logic             out_exception;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_zero, out_exception
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_zero, out_exception
  );
endinterface

// File: rtl/addsub_pipe_stage.sv
// Two-stage valid/ready add/sub/cmp pipeline; accept -> out_valid takes 2 edges, 1 op/cycle.
// Stalls in place when both stages are full and out_ready=0; in_ready is combinational.
module addsub_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  addsub_pipe_stage_if.slave bus,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;
    logic             exception;
  } res_t;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  res_t             s2_res;
  res_t             res_d;

  logic s2_free, s1_adv, in_ready_int, in_fire, out_fire;

  assign s2_free      = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_free;
  assign in_ready_int = !s1_valid || s2_free;
  assign in_fire      = bus.in_valid && in_ready_int;
  assign out_fire     = s2_valid && bus.out_ready;

  // Adder interface: subtraction is a + ~b + 1 via the carry-in.
  logic [WIDTH-1:0] i_1, i_2, raw;
  logic             invert_i_2, add_ovf;
  logic             sign_a, sign_b, sign_r;

  assign i_1        = s1_a;
  assign i_2        = s1_b;
  assign invert_i_2 = (s1_op != OP_ADD);
  assign raw        = i_1 + (invert_i_2 ? ~i_2 : i_2) + {{(WIDTH-1){1'b0}}, invert_i_2};
  assign sign_a     = i_1[WIDTH-1];
  assign sign_b     = i_2[WIDTH-1];
  assign sign_r     = raw[WIDTH-1];
  assign add_ovf    = (invert_i_2 ? (sign_a != sign_b) : (sign_a == sign_b)) && (sign_r != sign_a);

  always_comb begin
    res_d = '0;
    unique case (s1_op)
      OP_ADD, OP_SUB: begin
        res_d.result   = raw;
        res_d.overflow = add_ovf;
        res_d.zero     = (raw == '0);
      end
      OP_CMP: begin
        res_d.overflow = add_ovf;
        res_d.zero     = (raw == '0);
      end
      default: res_d.exception = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_res    <= '0;
      ovf_count <= '0;
    end else begin
      if (in_ready_int) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_op <= op_e'(bus.in_op);
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
      end
      if (s2_free) s2_valid <= s1_valid;
      if (s1_adv)  s2_res   <= res_d;
      // Saturate rather than wrap so software can tell "many" from "few".
      if (out_fire && s2_res.overflow && (ovf_count != {CNT_W{1'b1}}))
        ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready      = in_ready_int;
  assign bus.out_valid     = s2_valid;
  assign bus.out_result    = s2_res.result;
  assign bus.out_overflow  = s2_res.overflow;
  assign bus.out_zero      = s2_res.zero;
  assign bus.out_exception = s2_res.exception;

endmodule

// File: tb/tb_addsub_pipe_stage.sv
// Bench for addsub_pipe_stage: directed cases plus random traffic against an arithmetic model.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_addsub_pipe_stage;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] cnt_m;
  logic [1:0] cnt_s;

  always #5 clk = ~clk;

  addsub_pipe_stage_if #(.WIDTH(32)) bm ();
  addsub_pipe_stage_if #(.WIDTH(32)) bs ();

  assign bs.in_valid  = bm.in_valid;
  assign bs.in_op     = bm.in_op;
  assign bs.in_a      = bm.in_a;
  assign bs.in_b      = bm.in_b;
  assign bs.out_ready = bm.out_ready;

  addsub_pipe_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bm), .ovf_count(cnt_m)
  );

  addsub_pipe_stage #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bs), .ovf_count(cnt_s)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        exc;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  int          exp_cnt_s = 0;
  bit          in_fired = 0;
  bit          stall_prev = 0;
  logic [31:0] held_res;
  logic [2:0]  held_flags;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, overflow = true result outside 32-bit signed range.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, r;
    logic [31:0] low;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = (op == 2'd0) ? sa + sb : sa - sb;
    low = r[31:0];
    e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.zero = (low == 32'd0);
    e.res  = (op == 2'd2) ? 32'd0 : low;
    e.exc  = 1'b0;
    if (op == 2'd3) begin
      e = '0;
      e.exc = 1'b1;
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      exp_cnt_s = 0;
      stall_prev = 0;
      in_fired = 0;
    end else begin
      chk("ovf_count", {24'd0, cnt_m}, exp_cnt);
      chk("ovf_count_sat", {30'd0, cnt_s}, exp_cnt_s);
      if (stall_prev) begin
        chk("hold_vld", {31'd0, bm.out_valid}, 32'd1);
        chk("hold_res", bm.out_result, held_res);
        chk("hold_flags", {29'd0, bm.out_overflow, bm.out_zero, bm.out_exception},
            {29'd0, held_flags});
      end
      chk("in_ready", {31'd0, bm.in_ready}, {31'd0, (q.size() < 2) || bm.out_ready});
      chk("in_ready_sat", {31'd0, bs.in_ready}, {31'd0, (q.size() < 2) || bm.out_ready});
      in_fired = bm.in_valid && bm.in_ready;
      if (bm.out_valid && bm.out_ready) begin
        chk("spurious_out", q.size(), (q.size() > 0) ? q.size() : 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("result", bm.out_result, e.res);
          chk("flags", {29'd0, bm.out_overflow, bm.out_zero, bm.out_exception},
              {29'd0, e.ovf, e.zero, e.exc});
          chk("sat_vld", {31'd0, bs.out_valid}, 32'd1);
          chk("sat_result", bs.out_result, e.res);
          if (e.ovf) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_cnt_s < 3) exp_cnt_s++;
          end
        end
      end
      if (in_fired) q.push_back(model(bm.in_op, bm.in_a, bm.in_b));
      stall_prev = bm.out_valid && !bm.out_ready;
      held_res   = bm.out_result;
      held_flags = {bm.out_overflow, bm.out_zero, bm.out_exception};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bm.in_valid = 1'b1;
    bm.in_op    = op;
    bm.in_a     = a;
    bm.in_b     = b;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_fired) break;
    end
    chk("send_fired", {31'd0, in_fired}, 32'd1);
    bm.in_valid = 1'b0;
  endtask

  task automatic drain();
    bm.in_valid  = 1'b0;
    bm.out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'd0;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]  t4_op [4];
  logic [31:0] t4_a  [4];
  logic [31:0] t4_b  [4];
  int          idx;

  initial begin
    rst = 1'b1;
    bm.in_valid = 1'b0; bm.in_op = 2'd0; bm.in_a = '0; bm.in_b = '0; bm.out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bm.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bm.in_ready}, 32'd1);
    chk("rst_result", bm.out_result, 32'd0);
    chk("rst_flags", {29'd0, bm.out_overflow, bm.out_zero, bm.out_exception}, 32'd0);
    chk("rst_count", {24'd0, cnt_m}, 32'd0);

    // T1: latency of two edges
    bm.out_ready = 1'b1;
    send(2'd0, 32'd15, 32'd39);
    chk("t1_lat1_vld", {31'd0, bm.out_valid}, 32'd0);
    tick();
    chk("t1_lat2_vld", {31'd0, bm.out_valid}, 32'd1);
    chk("t1_result", bm.out_result, 32'd54);
    chk("t1_flags", {29'd0, bm.out_overflow, bm.out_zero, bm.out_exception}, 32'd0);
    drain();

    // T2 / T3 / T5 back-to-back
    send(2'd1, 32'd210, 32'd230);
    send(2'd1, 32'd272, 32'd272);
    send(2'd0, 32'h7FFF_FFFF, 32'd1);
    send(2'd1, 32'h8000_0000, 32'd1);
    send(2'd1, 32'd0, 32'h8000_0000);
    send(2'd2, 32'd5, 32'd5);
    send(2'd3, 32'd9, 32'd4);
    drain();
    tick();
    chk("t3_ovf_count", {24'd0, cnt_m}, 32'd3);
    send(2'd0, 32'h8000_0000, 32'h8000_0000);
    send(2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    drain();
    tick();
    chk("sat_hold", {30'd0, cnt_s}, 32'd3);
    chk("cnt_after_sat", {24'd0, cnt_m}, 32'd5);

    // T4: backpressure with 4 queued ops
    for (int i = 0; i < 4; i++) begin
      t4_op[i] = 2'($urandom_range(0, 2));
      t4_a[i]  = pick();
      t4_b[i]  = pick();
    end
    idx = 0;
    for (int c = 0; c < 40 && !(idx == 4 && q.size() == 0); c++) begin
      if (c == 5) begin
        chk("t4_accepted", idx, 32'd2);
        chk("t4_in_ready", {31'd0, bm.in_ready}, 32'd0);
      end
      bm.out_ready = (c >= 5);
      bm.in_valid  = (idx < 4);
      if (idx < 4) begin
        bm.in_op = t4_op[idx];
        bm.in_a  = t4_a[idx];
        bm.in_b  = t4_b[idx];
      end
      tick();
      if (in_fired) idx++;
    end
    chk("t4_all_sent", idx, 32'd4);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bm.in_valid  = ($urandom_range(0, 3) != 0);
      bm.out_ready = ($urandom_range(0, 3) != 0);
      bm.in_op     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bm.in_a      = pick();
      bm.in_b      = pick();
      tick();
    end
    drain();

    // T6: reset with both stages full
    bm.out_ready = 1'b0;
    send(2'd0, 32'h7FFF_FFFF, 32'd1);
    send(2'd1, 32'd1, 32'd2);
    #1;
    chk("t6_full", {31'd0, bm.in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_out_valid", {31'd0, bm.out_valid}, 32'd0);
    chk("t6_in_ready", {31'd0, bm.in_ready}, 32'd1);
    chk("t6_count", {24'd0, cnt_m}, 32'd0);
    chk("t6_count_sat", {30'd0, cnt_s}, 32'd0);
    bm.out_ready = 1'b1;
    send(2'd0, 32'd100, 32'hFFFF_FF9C);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
